// File: rtl/ddr3_app_sched.sv
// Write/read burst scheduler in front of a MIG DDR3 app interface: grants whole bursts of
// BURST_LEN commands to one side. Define DDR3_SCHED_RD_PRIO_EN for read priority with write anti-starvation.
module ddr3_app_sched #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 28,
   parameter int BURST_LEN  = 64,
   parameter int ADDR_STEP  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_calib_complete,
   input  logic                    wr_req,
   input  logic                    rd_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr_begin,
   input  logic [ADDR_WIDTH-1:0]   wr_addr_end,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_begin,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_end,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_rd,
   output logic [DATA_WIDTH-1:0]   rd_dout,
   output logic                    rd_dout_vld,
   output logic                    app_en,
   output logic [2:0]              app_cmd,
   output logic [ADDR_WIDTH-1:0]   app_addr,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   output logic [DATA_WIDTH-1:0]   app_wdf_data,
   output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                    app_rdy,
   input  logic                    app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid,
   output logic                    busy,
   output logic [1:0]              grant
);

   localparam int                   CNT_W     = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0]     BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH:0]  STEP      = (ADDR_WIDTH + 1)'(ADDR_STEP);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cmd_cnt;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                  last_grant_rd;
   logic                  pick_rd;
   logic                  cmd_ok;

   // The extra top bit catches a carry out of the address so it counts as "past the end".
   function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr,
                                                      input logic [ADDR_WIDTH-1:0] beg,
                                                      input logic [ADDR_WIDTH-1:0] fin);
      logic [ADDR_WIDTH:0] sum;
      sum = {1'b0, ptr} + STEP;
      return (sum > {1'b0, fin}) ? beg : sum[ADDR_WIDTH-1:0];
   endfunction

`ifdef DDR3_SCHED_RD_PRIO_EN
   logic [2:0] rd_streak;

   // Reads win unless four reads in a row have already been granted over a waiting write.
   assign pick_rd = rd_req & ~(wr_req & (rd_streak == 3'd4));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_streak <= 3'd0;
      end else if (init_calib_complete && state == IDLE && (wr_req || rd_req)) begin
         if (!pick_rd)
            rd_streak <= 3'd0;
         else if (wr_req && rd_streak != 3'd4)
            rd_streak <= rd_streak + 3'd1;
      end
   end
`else
   assign pick_rd = rd_req & (~wr_req | ~last_grant_rd);
`endif

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_nxt    = state;
      app_en       = 1'b0;
      app_cmd      = 3'b000;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      wr_data_rd   = 1'b0;
      cmd_ok       = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req || rd_req)
               state_nxt = pick_rd ? RD_BURST : WR_BURST;
         end
         WR_BURST: begin
            if (cmd_cnt < BURST_CNT) begin
               cmd_ok       = app_rdy & app_wdf_rdy;
               app_en       = cmd_ok;
               app_wdf_wren = cmd_ok;
               app_wdf_end  = cmd_ok;
               wr_data_rd   = cmd_ok;
            end
            if (cmd_ok && cmd_cnt == LAST_CNT)
               state_nxt = IDLE;
         end
         RD_BURST: begin
            app_cmd = 3'b001;
            if (cmd_cnt < BURST_CNT) begin
               cmd_ok = app_rdy;
               app_en = cmd_ok;
            end
            if (cmd_ok && cmd_cnt == LAST_CNT)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!init_calib_complete)
         state_nxt = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cmd_cnt       <= '0;
         wr_ptr        <= wr_addr_begin;
         rd_ptr        <= rd_addr_begin;
         last_grant_rd <= 1'b1;
         busy          <= 1'b0;
         grant         <= 2'b00;
      end else begin
         state <= state_nxt;
         if (!init_calib_complete) begin
            cmd_cnt <= '0;
            wr_ptr  <= wr_addr_begin;
            rd_ptr  <= rd_addr_begin;
            busy    <= 1'b0;
            grant   <= 2'b00;
         end else if (state == IDLE) begin
            if (wr_req || rd_req) begin
               busy          <= 1'b1;
               grant         <= pick_rd ? 2'b10 : 2'b01;
               last_grant_rd <= pick_rd;
            end
         end else if (cmd_ok) begin
            if (state == WR_BURST)
               wr_ptr <= next_ptr(wr_ptr, wr_addr_begin, wr_addr_end);
            else
               rd_ptr <= next_ptr(rd_ptr, rd_addr_begin, rd_addr_end);
            if (cmd_cnt == LAST_CNT) begin
               cmd_cnt <= '0;
               busy    <= 1'b0;
               grant   <= 2'b00;
            end else begin
               cmd_cnt <= cmd_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_dout     <= '0;
         rd_dout_vld <= 1'b0;
      end else begin
         rd_dout     <= app_rd_data;
         rd_dout_vld <= app_rd_data_valid;
      end
   end

   assign app_addr     = (state == RD_BURST) ? rd_ptr : wr_ptr;
   assign app_wdf_data = wr_data;
   assign app_wdf_mask = '0;

endmodule

// File: tb/tb_ddr3_app_sched.sv
// Directed bench for ddr3_app_sched with BURST_LEN=4, ADDR_STEP=8: a per-cycle vector table
// plus sequences for arbitration, read-data latency, calibration loss and reset mid-burst.
module tb_ddr3_app_sched;

   localparam int DW = 128;
   localparam int AW = 28;
   localparam logic [DW-1:0] WR_BASE = 128'h1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_calib_complete;
   logic          wr_req, rd_req;
   logic [AW-1:0] wr_addr_begin, wr_addr_end, rd_addr_begin, rd_addr_end;
   logic [DW-1:0] wr_data;
   logic          wr_data_rd;
   logic [DW-1:0] rd_dout;
   logic          rd_dout_vld;
   logic          app_en;
   logic [2:0]    app_cmd;
   logic [AW-1:0] app_addr;
   logic          app_wdf_wren, app_wdf_end;
   logic [DW-1:0] app_wdf_data;
   logic [DW/8-1:0] app_wdf_mask;
   logic          app_rdy, app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          busy;
   logic [1:0]    grant;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;
   logic [DW-1:0] wr_log[$];

   ddr3_app_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4), .ADDR_STEP(8)) dut (
      .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
      .wr_req(wr_req), .rd_req(rd_req),
      .wr_addr_begin(wr_addr_begin), .wr_addr_end(wr_addr_end),
      .rd_addr_begin(rd_addr_begin), .rd_addr_end(rd_addr_end),
      .wr_data(wr_data), .wr_data_rd(wr_data_rd),
      .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   // FWFT write FIFO model: head word is WR_BASE + number of pops so far.
   always @(posedge clk) begin
      if (wr_data_rd) begin
         wr_log.push_back(app_wdf_data);
         pops    = pops + 1;
         wr_data = WR_BASE + DW'(pops);
      end
   end

   typedef struct {
      logic          wr, rd, rdy, wdf;
      logic          en;
      logic [2:0]    cmd;
      logic          wren;
      logic [AW-1:0] addr;
      logic          bsy;
      logic [1:0]    gnt;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(logic wr, logic rd, logic rdy, logic wdf, logic en, logic [2:0] cmd,
                               logic wren, logic [AW-1:0] addr, logic bsy, logic [1:0] gnt);
      vec_t v;
      v.wr = wr; v.rd = rd; v.rdy = rdy; v.wdf = wdf; v.en = en; v.cmd = cmd;
      v.wren = wren; v.addr = addr; v.bsy = bsy; v.gnt = gnt;
      return v;
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic wait_busy(input logic lvl, input string nm);
      int n = 0;
      while (busy !== lvl && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(nm, DW'(busy), DW'(lvl));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   logic [1:0]    exp_gnt[5];
   logic          vld_seq[5];
   logic [DW-1:0] dat_seq[5];

   initial begin
      rst = 1'b1; init_calib_complete = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      wr_addr_begin = 28'h0; wr_addr_end = 28'h1F; rd_addr_begin = 28'h100; rd_addr_end = 28'h10F;
      wr_data = WR_BASE; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data = {16{8'hA5}}; app_rd_data_valid = 1'b1;

      // Reset state, with requests and read-valid held high to prove nothing leaks through.
      cyc(); cyc(); smp();
      check("rst_busy", DW'(busy), 0);
      check("rst_grant", DW'(grant), 0);
      check("rst_app_en", DW'(app_en), 0);
      check("rst_app_cmd", DW'(app_cmd), 0);
      check("rst_wren", DW'(app_wdf_wren), 0);
      check("rst_wdf_end", DW'(app_wdf_end), 0);
      check("rst_wr_data_rd", DW'(wr_data_rd), 0);
      check("rst_rd_dout_vld", DW'(rd_dout_vld), 0);
      check("rst_rd_dout", rd_dout, 0);
      check("rst_app_addr", DW'(app_addr), 0);
      wr_req = 1'b0; rd_req = 1'b0; app_rd_data_valid = 1'b0;
      cyc();
      rst = 1'b0;

      // Write burst with wdf stall and app_rdy gap, then a read burst that wraps its window.
      tbl[0]  = mk(0, 0, 1, 1, 0, 3'd0, 0, 28'h000, 0, 2'b00);
      tbl[1]  = mk(1, 0, 1, 1, 0, 3'd0, 0, 28'h000, 0, 2'b00);
      tbl[2]  = mk(0, 0, 1, 1, 1, 3'd0, 1, 28'h000, 1, 2'b01);
      tbl[3]  = mk(0, 0, 1, 0, 0, 3'd0, 0, 28'h008, 1, 2'b01);
      tbl[4]  = mk(0, 0, 1, 0, 0, 3'd0, 0, 28'h008, 1, 2'b01);
      tbl[5]  = mk(0, 0, 1, 0, 0, 3'd0, 0, 28'h008, 1, 2'b01);
      tbl[6]  = mk(0, 0, 1, 1, 1, 3'd0, 1, 28'h008, 1, 2'b01);
      tbl[7]  = mk(0, 0, 0, 1, 0, 3'd0, 0, 28'h010, 1, 2'b01);
      tbl[8]  = mk(0, 0, 1, 1, 1, 3'd0, 1, 28'h010, 1, 2'b01);
      tbl[9]  = mk(0, 0, 1, 1, 1, 3'd0, 1, 28'h018, 1, 2'b01);
      tbl[10] = mk(1, 1, 1, 1, 0, 3'd0, 0, 28'h000, 0, 2'b00);
      tbl[11] = mk(0, 0, 1, 1, 1, 3'd1, 0, 28'h100, 1, 2'b10);
      tbl[12] = mk(0, 0, 0, 1, 0, 3'd1, 0, 28'h108, 1, 2'b10);
      tbl[13] = mk(0, 0, 1, 1, 1, 3'd1, 0, 28'h108, 1, 2'b10);
      tbl[14] = mk(0, 0, 1, 1, 1, 3'd1, 0, 28'h100, 1, 2'b10);
      tbl[15] = mk(0, 0, 1, 1, 1, 3'd1, 0, 28'h108, 1, 2'b10);
      tbl[16] = mk(0, 0, 1, 1, 0, 3'd0, 0, 28'h000, 0, 2'b00);
      wr_log.delete();
      pops = 0;
      wr_data = WR_BASE;
      for (int i = 0; i < 17; i++) begin
         cyc();
         wr_req = tbl[i].wr; rd_req = tbl[i].rd; app_rdy = tbl[i].rdy; app_wdf_rdy = tbl[i].wdf;
         smp();
         check($sformatf("v%0d_app_en", i), DW'(app_en), DW'(tbl[i].en));
         check($sformatf("v%0d_app_cmd", i), DW'(app_cmd), DW'(tbl[i].cmd));
         check($sformatf("v%0d_wren", i), DW'(app_wdf_wren), DW'(tbl[i].wren));
         check($sformatf("v%0d_wdf_end", i), DW'(app_wdf_end), DW'(tbl[i].wren));
         check($sformatf("v%0d_wr_data_rd", i), DW'(wr_data_rd), DW'(tbl[i].wren));
         check($sformatf("v%0d_app_addr", i), DW'(app_addr), DW'(tbl[i].addr));
         check($sformatf("v%0d_busy", i), DW'(busy), DW'(tbl[i].bsy));
         check($sformatf("v%0d_grant", i), DW'(grant), DW'(tbl[i].gnt));
         check($sformatf("v%0d_mask", i), DW'(app_wdf_mask), 0);
      end
      check("wr_pop_count", DW'(wr_log.size()), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         check($sformatf("wr_word%0d", i), wr_log[i], WR_BASE + DW'(i));

      // Continuous contention from a fresh reset.
`ifdef DDR3_SCHED_RD_PRIO_EN
      exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
      do_reset();
      wr_req = 1'b1; rd_req = 1'b1;
      smp();
      for (int b = 0; b < 5; b++) begin
         wait_busy(1'b1, $sformatf("arb%0d_start", b));
         check($sformatf("arb%0d_grant", b), DW'(grant), DW'(exp_gnt[b]));
         wait_busy(1'b0, $sformatf("arb%0d_end", b));
      end
      wr_req = 1'b0; rd_req = 1'b0;
      cyc(); cyc();
      wait_busy(1'b0, "arb_drain");

      // Read return path: registered, one cycle late, back-to-back pulses included.
      vld_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      dat_seq = '{{16{8'hA5}}, {8{16'hA55A}}, 128'h0, {4{32'hA5C3_0F11}}, 128'h0};
      for (int i = 0; i < 5; i++) begin
         cyc();
         app_rd_data_valid = vld_seq[i];
         app_rd_data = dat_seq[i];
         smp();
         if (i > 0) begin
            check($sformatf("rdv%0d_vld", i), DW'(rd_dout_vld), DW'(vld_seq[i-1]));
            if (vld_seq[i-1])
               check($sformatf("rdv%0d_data", i), rd_dout, dat_seq[i-1]);
         end
      end
      cyc();
      smp();
      check("rdv_tail_vld", DW'(rd_dout_vld), 0);

      // Calibration loss after the second read command.
      wr_addr_begin = 28'h40; wr_addr_end = 28'h7F; rd_addr_begin = 28'h100; rd_addr_end = 28'h13F;
      do_reset();
      rd_req = 1'b1;
      cyc();
      rd_req = 1'b0;
      smp();
      check("cal_b_busy", DW'(busy), 1);
      check("cal_b_grant", DW'(grant), 2'b10);
      check("cal_b_addr", DW'(app_addr), 28'h100);
      cyc(); smp();
      check("cal_c_addr", DW'(app_addr), 28'h108);
      cyc();
      init_calib_complete = 1'b0;
      smp();
      check("cal_d_addr", DW'(app_addr), 28'h110);
      cyc(); smp();
      check("cal_e_busy", DW'(busy), 0);
      check("cal_e_grant", DW'(grant), 0);
      check("cal_e_app_en", DW'(app_en), 0);
      check("cal_e_addr", DW'(app_addr), 28'h40);
      init_calib_complete = 1'b1;
      rd_req = 1'b1;
      cyc();
      rd_req = 1'b0;
      smp();
      check("cal_f_busy", DW'(busy), 1);
      check("cal_f_addr", DW'(app_addr), 28'h100);
      wait_busy(1'b0, "cal_drain");

      // Asynchronous reset in the middle of a write burst.
      wr_req = 1'b1;
      cyc();
      wr_req = 1'b0;
      smp();
      check("mid_busy_before", DW'(busy), 1);
      cyc();
      rst = 1'b1;
      #1;
      check("mid_busy", DW'(busy), 0);
      check("mid_grant", DW'(grant), 0);
      check("mid_app_en", DW'(app_en), 0);
      check("mid_wren", DW'(app_wdf_wren), 0);
      check("mid_wdf_end", DW'(app_wdf_end), 0);
      check("mid_wr_data_rd", DW'(wr_data_rd), 0);
      check("mid_app_cmd", DW'(app_cmd), 0);
      check("mid_addr", DW'(app_addr), 28'h40);
      cyc();
      rst = 1'b0;
      cyc(); smp();
      check("post_rst_idle", DW'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr3_app_sched.md
DDR3_APP_SCHED -- requirements
Module: ddr3_app_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning MIG app data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 28, meaning MIG app address width.
REQ-003 SHALL have parameter BURST_LEN, default 64, meaning app commands per granted burst (power of 2, 2..256).
REQ-004 SHALL have parameter ADDR_STEP, default 8, meaning app_addr increment per command.
REQ-005 SHALL have port clk, input, 1, the single clock (MIG ui_clk); all logic synchronous to it.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port init_calib_complete, input, 1, high when MIG calibration is done.
REQ-008 SHALL have ports wr_req, input, 1, write FIFO holds at least BURST_LEN words; rd_req, input, 1, read FIFO has room for BURST_LEN words.
REQ-009 SHALL have ports wr_addr_begin/wr_addr_end/rd_addr_begin/rd_addr_end, input, ADDR_WIDTH each, inclusive circular address windows.
REQ-010 SHALL have ports wr_data, input, DATA_WIDTH, FWFT write FIFO head; wr_data_rd, output, 1, write FIFO pop.
REQ-011 SHALL have ports rd_dout, output, DATA_WIDTH, and rd_dout_vld, output, 1, read FIFO push.
REQ-012 SHALL have MIG ports app_en/app_cmd[2:0]/app_addr/app_wdf_wren/app_wdf_end/app_wdf_data/app_wdf_mask (outputs), app_rdy/app_wdf_rdy/app_rd_data/app_rd_data_valid (inputs).
REQ-013 SHALL have outputs busy, 1, burst in progress, and grant, 2, {rd,wr} one-hot owner of the current burst.

Function
REQ-014 SHALL implement states IDLE, WR_BURST, RD_BURST.
REQ-015 IDLE: when init_calib_complete is high and at least one request is high, SHALL move to the granted burst state on the next edge; grant and busy update on that same edge.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the side not granted last wins; with one request high, that side wins; the last-grant flag resets to "read", so a write wins the first tie.
REQ-017 WR_BURST: app_en, app_wdf_wren, app_wdf_end and wr_data_rd SHALL all equal app_rdy & app_wdf_rdy (combinational) while cmd_cnt < BURST_LEN; app_cmd SHALL be 3'b000; app_wdf_data SHALL be wr_data; app_wdf_mask SHALL be all zeros.
REQ-018 RD_BURST: app_en SHALL equal app_rdy while cmd_cnt < BURST_LEN; app_cmd SHALL be 3'b001; write strobes SHALL be low.
REQ-019 Each accepted command SHALL increment cmd_cnt and advance that side's address pointer.
REQ-020 After the BURST_LEN-th accepted command, the block SHALL return to IDLE on the next edge, clear cmd_cnt, and clear busy and grant.
REQ-021 Pointer advance: if ptr + ADDR_STEP > end, then next = begin; otherwise next = ptr + ADDR_STEP. Arithmetic is ADDR_WIDTH+1 bits wide, so a carry counts as "> end".
REQ-022 app_addr SHALL show the active side's pointer; in IDLE it SHALL show the write pointer with app_en low.
REQ-023 rd_dout/rd_dout_vld SHALL be app_rd_data/app_rd_data_valid registered, 1-cycle latency, in every state.
REQ-024 A request deasserting mid-burst SHALL NOT abort the burst; requests are sampled only in IDLE.
REQ-025 init_calib_complete low in any state SHALL force IDLE next edge and reload both pointers to their begin values; the partial burst is dropped.
REQ-026 Window edits while busy SHALL only take effect at the next wrap or reload.

Reset
REQ-027 On rst high, asynchronously: state IDLE, cmd_cnt 0, pointers to begin values, last-grant "read", busy 0, grant 2'b00, rd_dout 0, rd_dout_vld 0.
REQ-028 With rst high, every combinational strobe SHALL be 0 (app_en, app_wdf_wren, app_wdf_end, wr_data_rd), and app_cmd SHALL be 3'b000.

Configuration
REQ-029 Macro DDR3_SCHED_RD_PRIO_EN defined: reads SHALL have strict priority, except that after 4 consecutive read grants with wr_req high a write SHALL be granted. Priority counter resets to 0 and clears on any write grant.
REQ-030 Macro DDR3_SCHED_RD_PRIO_EN undefined: pure round-robin per REQ-016, and no counter logic is present.

Verification (BURST_LEN=4, ADDR_STEP=8)
REQ-031 wr_req=1 only, window 0..0x1F, rdy always 1 -> 4 writes at 0x00/0x08/0x10/0x18, wr_data_rd 4 pulses, next burst restarts at 0x00.
REQ-032 wr_req=rd_req=1 continuously -> grants alternate WR,RD,WR,RD (RD_PRIO off); with RD_PRIO_EN -> RD,RD,RD,RD,WR.
REQ-033 app_wdf_rdy low for 3 cycles mid write burst -> no strobes during those cycles, exactly 4 commands total, no lost or duplicated data.
REQ-034 app_rd_data_valid pulses with 0xA5.. data -> rd_dout_vld and data appear exactly 1 cycle later.
REQ-035 init_calib_complete drops after the 2nd read command -> IDLE next cycle, busy 0, read pointer back to rd_addr_begin; rst mid-burst -> all outputs at REQ-027/028 values immediately.
